// File: rtl/uint2float_pipe.sv
// Three-stage integer to IEEE-754 single-precision converter with valid/ready flow control.
// Inputs up to 24 bits convert exactly; an optional power-of-two scale is folded into the exponent.
module uint2float_pipe #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned SIGNED    = 0,
  parameter int          SCALE_EXP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [31:0]     out_float,
  output logic            out_valid,
  input  logic            out_ready
);

  if (IN_W < 1 || IN_W > 24 || SCALE_EXP < -100 || SCALE_EXP > 100) begin : g_bad_params
    $error("uint2float_pipe: IN_W must be 1..24 and SCALE_EXP -100..100");
  end

  logic            advance;

  logic            v1_q, s1_q;
  logic [IN_W-1:0] m1_q;
  logic            v2_q, s2_q, z2_q;
  logic [IN_W-1:0] m2_q;
  logic [4:0]      p2_q;
  logic            v3_q;
  logic [31:0]     f3_q;

  logic            s1_d;
  logic [IN_W-1:0] m1_d;
  logic [4:0]      p2_d;
  logic            z2_d;
  logic [22:0]     frac;
  logic [7:0]      expo;
  logic [31:0]     f3_d;

  // Any stage may move only when the output slot is free or being drained.
  assign advance   = out_ready || !v3_q;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign out_float = f3_q;

  // Negation stays IN_W wide so the most negative value maps to magnitude 2^(IN_W-1).
  always_comb begin
    s1_d = (SIGNED != 0) && in_data[IN_W-1];
    m1_d = s1_d ? (~in_data + IN_W'(1)) : in_data;
  end

  always_comb begin
    p2_d = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (m1_q[i]) p2_d = 5'(i);
    end
    z2_d = (m1_q == '0);
  end

  always_comb begin
    frac = 23'(24'(m2_q) << (5'd23 - p2_q));
    expo = 8'(127 + int'(p2_q) + SCALE_EXP);
    f3_d = z2_q ? 32'h0000_0000 : {s2_q, expo, frac};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      s1_q <= 1'b0;
      m1_q <= '0;
      v2_q <= 1'b0;
      s2_q <= 1'b0;
      z2_q <= 1'b1;
      m2_q <= '0;
      p2_q <= '0;
      v3_q <= 1'b0;
      f3_q <= '0;
    end else if (advance) begin
      v1_q <= in_valid && in_ready;
      s1_q <= s1_d;
      m1_q <= m1_d;
      v2_q <= v1_q;
      s2_q <= s1_q;
      z2_q <= z2_d;
      m2_q <= m1_q;
      p2_q <= p2_d;
      v3_q <= v2_q;
      f3_q <= f3_d;
    end
  end

endmodule

// File: tb/tb_uint2float_pipe.sv
// Directed bench for uint2float_pipe: four parameterisations share one stimulus bus,
// selected by sel; each test task drives and checks its own vectors.
module tb_uint2float_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] din = '0;
  logic        vin = 1'b0;
  logic        ordy = 1'b1;
  logic [1:0]  sel = 2'd0;

  logic [3:0]  ir, ov;
  logic [31:0] of0, of1, of2, of3;
  logic [31:0] of_m;
  logic        ov_m, ir_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uint2float_pipe #(.IN_W(8), .SIGNED(0), .SCALE_EXP(0)) u_u8 (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(vin && sel == 2'd0),
    .in_ready(ir[0]), .out_float(of0), .out_valid(ov[0]), .out_ready(ordy)
  );
  uint2float_pipe #(.IN_W(8), .SIGNED(0), .SCALE_EXP(-8)) u_u8s (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(vin && sel == 2'd1),
    .in_ready(ir[1]), .out_float(of1), .out_valid(ov[1]), .out_ready(ordy)
  );
  uint2float_pipe #(.IN_W(8), .SIGNED(1), .SCALE_EXP(0)) u_s8 (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(vin && sel == 2'd2),
    .in_ready(ir[2]), .out_float(of2), .out_valid(ov[2]), .out_ready(ordy)
  );
  uint2float_pipe #(.IN_W(24), .SIGNED(0), .SCALE_EXP(0)) u_u24 (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vin && sel == 2'd3),
    .in_ready(ir[3]), .out_float(of3), .out_valid(ov[3]), .out_ready(ordy)
  );

  always_comb begin
    ov_m = ov[sel];
    ir_m = ir[sel];
    case (sel)
      2'd0:    of_m = of0;
      2'd1:    of_m = of1;
      2'd2:    of_m = of2;
      default: of_m = of3;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sel = 2'd0; vin = 1'b1; din = 24'd9; ordy = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0; vin = 1'b0;
    #1;
    checks++;
    if (ir !== 4'hF || ov !== 4'h0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b, required 1111 0000", ir, ov);
    end
    checks++;
    if ({of0, of1, of2, of3} !== 128'h0) begin
      errors++;
      $display("FAIL reset_float: %h %h %h %h, required all 00000000", of0, of1, of2, of3);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (ov !== 4'h0) begin
        errors++;
        $display("FAIL reset_capture c%0d: out_valid=%b, required 0000", c, ov);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [23:0] d[5] = '{24'd0, 24'd1, 24'd2, 24'd3, 24'd255};
    logic [31:0] e[5] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                          32'h437F_0000};
    sel = 2'd0; ordy = 1'b1;
    for (int c = 0; c < 7; c++) begin
      vin = (c < 5);
      din = (c < 5) ? d[c] : 24'd0;
      tick();
      checks++;
      if (c < 2) begin
        if (ov_m !== 1'b0) begin
          errors++;
          $display("FAIL unsigned_latency c%0d: out_valid=%b, required 0", c, ov_m);
        end
      end else if (ov_m !== 1'b1 || of_m !== e[c-2]) begin
        errors++;
        $display("FAIL unsigned_%0d: valid=%b float=%h, required 1 %h", c - 2, ov_m, of_m, e[c-2]);
      end
    end
    vin = 1'b0;
    tick();
    checks++;
    if (ov_m !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_drain: out_valid=%b, required 0", ov_m);
    end
  endtask

  task automatic test_scale();
    logic [23:0] d[3] = '{24'd128, 24'd255, 24'd0};
    logic [31:0] e[3] = '{32'h3F00_0000, 32'h3F7F_0000, 32'h0000_0000};
    sel = 2'd1; ordy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vin = (c < 3);
      din = (c < 3) ? d[c] : 24'd0;
      tick();
      if (c >= 2) begin
        checks++;
        if (ov_m !== 1'b1 || of_m !== e[c-2]) begin
          errors++;
          $display("FAIL scale_%0d: valid=%b float=%h, required 1 %h", c - 2, ov_m, of_m, e[c-2]);
        end
      end
    end
    vin = 1'b0;
    tick();
  endtask

  task automatic test_signed();
    logic [23:0] d[4] = '{24'h80, 24'hFF, 24'h7F, 24'h00};
    logic [31:0] e[4] = '{32'hC300_0000, 32'hBF80_0000, 32'h42FE_0000, 32'h0000_0000};
    sel = 2'd2; ordy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      vin = (c < 4);
      din = (c < 4) ? d[c] : 24'd0;
      tick();
      if (c >= 2) begin
        checks++;
        if (ov_m !== 1'b1 || of_m !== e[c-2]) begin
          errors++;
          $display("FAIL signed_%0d: valid=%b float=%h, required 1 %h", c - 2, ov_m, of_m, e[c-2]);
        end
      end
    end
    vin = 1'b0;
    tick();
  endtask

  task automatic test_wide();
    logic [23:0] d[3] = '{24'hFF_FFFF, 24'h80_0000, 24'h00_0001};
    logic [31:0] e[3] = '{32'h4B7F_FFFF, 32'h4B00_0000, 32'h3F80_0000};
    sel = 2'd3; ordy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vin = (c < 3);
      din = (c < 3) ? d[c] : 24'd0;
      tick();
      if (c >= 2) begin
        checks++;
        if (ov_m !== 1'b1 || of_m !== e[c-2]) begin
          errors++;
          $display("FAIL wide_%0d: valid=%b float=%h, required 1 %h", c - 2, ov_m, of_m, e[c-2]);
        end
      end
    end
    vin = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] e[10] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                           32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                           32'h4110_0000, 32'h4120_0000};
    logic [31:0] pat = 32'b1011_0010_1110_0101_0011_0110_1000_1101;
    logic [31:0] held_val = '0;
    logic        held = 1'b0;
    int          next_in = 0;
    int          next_out = 0;
    sel = 2'd0;
    for (int c = 0; c < 200 && next_out < 10; c++) begin
      ordy = pat[c % 32];
      vin  = (next_in < 10);
      din  = 24'(next_in + 1);
      #1;
      checks++;
      if (ir_m !== (ordy || !ov_m)) begin
        errors++;
        $display("FAIL bp_ready c%0d: in_ready=%b, required %b", c, ir_m, ordy || !ov_m);
      end
      if (held) begin
        checks++;
        if (ov_m !== 1'b1 || of_m !== held_val) begin
          errors++;
          $display("FAIL bp_hold c%0d: valid=%b float=%h, required 1 %h", c, ov_m, of_m, held_val);
        end
      end
      if (ov_m === 1'b1 && ordy) begin
        checks++;
        if (of_m !== e[next_out]) begin
          errors++;
          $display("FAIL bp_order_%0d: float=%h, required %h", next_out, of_m, e[next_out]);
        end
        next_out++;
      end
      held     = (ov_m === 1'b1) && !ordy;
      held_val = of_m;
      if (vin && ir_m === 1'b1) next_in++;
      tick();
    end
    checks++;
    if (next_out != 10) begin
      errors++;
      $display("FAIL bp_count: outputs=%0d, required 10", next_out);
    end
    vin = 1'b0; ordy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (ov_m !== 1'b0) begin
        errors++;
        $display("FAIL bp_extra c%0d: out_valid=%b, required 0", c, ov_m);
      end
    end
  endtask

  task automatic test_midstream_reset();
    sel = 2'd0; ordy = 1'b1;
    vin = 1'b1; din = 24'd5;
    tick();
    din = 24'd7;
    tick();
    vin = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ov_m !== 1'b0 || of_m !== 32'h0 || ir_m !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%b float=%h ready=%b, required 0 00000000 1",
               ov_m, of_m, ir_m);
    end
    vin = 1'b1; din = 24'd3;
    for (int c = 0; c < 5; c++) begin
      tick();
      vin = 1'b0;
      checks++;
      if (c == 2) begin
        if (ov_m !== 1'b1 || of_m !== 32'h4040_0000) begin
          errors++;
          $display("FAIL post_reset_result: valid=%b float=%h, required 1 40400000", ov_m, of_m);
        end
      end else if (ov_m !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_stale c%0d: valid=%b float=%h, required 0", c, ov_m, of_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_scale();
    test_signed();
    test_wide();
    test_backpressure();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uint2float_pipe.md
Name: uint2float_pipe

Overview:
- Parametrised, pipelined integer-to-IEEE-754 single-precision converter; successor to the combinational 8-bit pixel converter.
- Accepts unsigned or two's-complement integers up to 24 bits, so every conversion is exact.
- Applies an optional power-of-two scale, e.g. 2^-8 to map 0..255 pixels into [0,1).
- Sits between the pixel/feature source and the floating-point classifier datapath, with valid/ready flow control on both sides.

Parameters:
- IN_W, 8, input integer width; legal range 1..24.
- SIGNED, 0, 0 = input is unsigned; 1 = input is two's complement.
- SCALE_EXP, 0, signed exponent offset added to every non-zero result; legal range -100..100.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  IN_W  integer to convert.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  converter accepts in_data this cycle.
- out_float  out  32  result: bit 31 sign, bits 30:23 exponent, bits 22:0 fraction.
- out_valid  out  1  out_float is valid this cycle.
- out_ready  in  1  downstream accepts out_float this cycle.

Behaviour:
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Pipeline: three register stages, each holding a valid bit.
  - S1: capture sign and magnitude. SIGNED=1 and MSB=1 gives sign=1 and magnitude = two's-complement negation, IN_W bits wide, so -2^(IN_W-1) is held correctly. Otherwise sign=0 and magnitude = in_data.
  - S2: leading-one detect. Priority encoder gives msb_pos (0..IN_W-1) and a zero flag.
  - S3: normalise and pack.
    - fraction = magnitude shifted left by (23 - msb_pos), leading one dropped, 23 bits.
    - exponent = 127 + msb_pos + SCALE_EXP, 8 bits.
    - Zero input gives out_float = 32'h00000000 (+0, sign forced 0, SCALE_EXP ignored).
- Latency: exactly 3 cycles from input transfer to out_valid when never stalled.
- Throughput: one conversion per cycle.
- Flow control:
  - advance = out_ready || !out_valid.
  - in_ready = advance; it is combinational from out_ready and must not depend on in_valid.
  - When advance=0, all stage registers and valid bits hold. out_float stays stable while out_valid=1 and out_ready=0.
  - When advance=1, every stage shifts by one. S1 valid loads in_valid && in_ready.
  - Bubbles propagate as invalid stages; bubble collapsing is not required.
- Ordering: strictly in order, no drop, no duplication.
- Reset:
  - All valid bits clear to 0 and out_float clears to 0; in_ready=1 follows after reset since out_valid=0.
  - Reset mid-stream discards all in-flight data.
  - in_valid asserted in the same cycle as rst is not captured.
- Exponent range: parameter legality guarantees no overflow or underflow, so no saturation logic is needed.
- Parameter checks: IN_W>24 or SCALE_EXP outside -100..100 must fail elaboration.
- No combinational path from in_data to out_float.

Test Plan:
1. IN_W=8, SIGNED=0, SCALE_EXP=0; stream 0,1,2,3,255 back-to-back with out_ready=1 -> out_float 00000000, 3F800000, 40000000, 40400000, 437F0000; each result arrives 3 cycles after its input, one per cycle.
2. SCALE_EXP=-8; inputs 128, 255, 0 -> 3F000000, 3F7F0000, 00000000 (zero ignores scale).
3. IN_W=8, SIGNED=1; inputs 8'h80, 8'hFF, 8'h7F -> C3000000, BF800000, 42FE0000.
4. IN_W=24; inputs 24'hFFFFFF and 24'h800000 -> 4B7FFFFF, 4B000000 (exact, no rounding).
5. Backpressure: stream 1..10 with out_ready toggling pseudo-randomly.
   - All ten results appear in order with no loss.
   - out_float is stable while out_valid=1 and out_ready=0.
   - in_ready equals out_ready || !out_valid every cycle.
6. Reset: assert rst for 1 cycle with 2 conversions in flight.
   - Next cycle: out_valid=0, out_float=0, in_ready=1.
   - No stale result ever appears; the first post-reset input emerges after exactly 3 cycles.
